// File: rtl/mips_pkg.sv
// mips_pkg: shared ISA constants, FSM state encoding and datapath select encodings
package mips_pkg;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SRA = 6'h03, F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2a;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2, S_WB_ALU = 4'd3, S_ADDR = 4'd4,
    S_MEM_RD = 4'd5, S_WB_MEM = 4'd6, S_MEM_WR = 4'd7, S_BRANCH = 4'd8, S_JUMP = 4'd9
  } state_e;
  typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_J, NPC_JR} npc_sel_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI, ALU_SLT, ALU_SRA} alu_op_e;
  typedef enum logic [1:0] {B_REG, B_SEXT, B_ZEXT} b_sel_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} reg_dst_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC} wb_src_e;
  typedef struct packed {
    logic zero;
    logic positive;
    logic overflow;
    logic signed_less;
  } alu_flags_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/mips_ctrl_if.sv
// mips_ctrl_if: decode fields and ALU flags from the datapath, control strobes back from the controller
interface mips_ctrl_if;
  import mips_pkg::*;
  logic [5:0] opcode;
  logic [5:0] funct;
  alu_flags_t flags;
  state_e state;
  logic pc_write;
  logic ir_write;
  logic ab_write;
  logic alu_write;
  logic mdr_write;
  logic reg_write;
  logic mem_write;
  npc_sel_e npc_sel;
  alu_op_e alu_op;
  b_sel_e b_sel;
  reg_dst_e reg_dst;
  wb_src_e wb_src;
  modport master(
    input opcode, funct, flags,
    output state, pc_write, ir_write, ab_write, alu_write, mdr_write, reg_write, mem_write,
    output npc_sel, alu_op, b_sel, reg_dst, wb_src
  );
  modport slave(
    output opcode, funct, flags,
    input state, pc_write, ir_write, ab_write, alu_write, mdr_write, reg_write, mem_write,
    input npc_sel, alu_op, b_sel, reg_dst, wb_src
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle FSM and instruction decode producing datapath strobes
module mips_mc_ctrl
  import mips_pkg::*;
(
  input logic clk,
  input logic rst,
  mips_ctrl_if.master c
);
  state_e r_state, w_next;
  logic w_r, w_alu_cls, w_mem, w_jmp;
  assign w_r = c.opcode == OP_R;
  assign w_alu_cls = (w_r && (c.funct inside {F_ADDU, F_SUBU, F_SLT, F_SRA})) ||
                     (c.opcode inside {OP_ADDI, OP_ORI, OP_LUI});
  assign w_mem = c.opcode inside {OP_LW, OP_SW};
  assign w_jmp = (c.opcode inside {OP_J, OP_JAL}) || (w_r && c.funct == F_JR);
  assign c.state = r_state;
  always_ff @(posedge clk) r_state <= rst ? S_FETCH : w_next;
  always_comb begin
    w_next = S_FETCH;
    c.pc_write = 1'b0;
    c.ir_write = 1'b0;
    c.ab_write = 1'b0;
    c.alu_write = 1'b0;
    c.mdr_write = 1'b0;
    c.reg_write = 1'b0;
    c.mem_write = 1'b0;
    c.npc_sel = NPC_SEQ;
    c.wb_src = WB_ALU;
    c.reg_dst = w_r ? DST_RD : DST_RT;
    c.b_sel = (w_r || c.opcode == OP_BEQ) ? B_REG : (c.opcode inside {OP_ORI, OP_LUI}) ? B_ZEXT : B_SEXT;
    c.alu_op = c.opcode == OP_ORI ? ALU_OR :
               c.opcode == OP_LUI ? ALU_LUI :
               c.opcode == OP_BEQ ? ALU_SUB :
               !w_r               ? ALU_ADD :
               c.funct == F_SUBU  ? ALU_SUB :
               c.funct == F_SLT   ? ALU_SLT :
               c.funct == F_SRA   ? ALU_SRA : ALU_ADD;
    case (r_state)
      S_FETCH: begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        c.ab_write = 1'b1;
        w_next = w_alu_cls ? S_EXEC : w_mem ? S_ADDR : c.opcode == OP_BEQ ? S_BRANCH : w_jmp ? S_JUMP : S_FETCH;
      end
      S_EXEC: begin
        c.alu_write = 1'b1;
        w_next = S_WB_ALU;
      end
      // ALU operands are still held in A/B/IR, so the overflow flag is live here
      S_WB_ALU: c.reg_write = !(c.opcode == OP_ADDI && c.flags.overflow);
      S_ADDR: begin
        c.alu_write = 1'b1;
        w_next = c.opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mdr_write = 1'b1;
        w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        c.reg_write = 1'b1;
        c.wb_src = WB_MEM;
      end
      S_MEM_WR: c.mem_write = 1'b1;
      S_BRANCH: begin
        c.pc_write = c.flags.zero;
        c.npc_sel = NPC_BR;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.npc_sel = w_r ? NPC_JR : NPC_J;
        c.reg_write = c.opcode == OP_JAL;
        c.reg_dst = DST_RA;
        c.wb_src = WB_PC;
      end
      default: w_next = S_FETCH;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_cpu.sv
// mips_multicycle_cpu: multi-cycle MIPS subset datapath (PC, IM, GPR, ALU, DM) around mips_mc_ctrl
module mips_multicycle_cpu
  import mips_pkg::*;
#(
  parameter int IM_WORDS = 1024,
  parameter int DM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int IW = $clog2(IM_WORDS);
  localparam int DW = $clog2(DM_WORDS);
  mips_ctrl_if c_if ();
  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
  logic [31:0] r_gpr [32];
  logic [31:0] r_dm [DM_WORDS];
  logic [31:0] r_im [IM_WORDS];
  logic [31:0] w_imm, w_b, w_sum, w_diff, w_sra, w_y, w_wd, w_npc;
  logic [4:0] w_dst;
  logic [IW-1:0] w_im_idx;
  logic [DW-1:0] w_dm_idx;
  logic w_lt;
  mips_mc_ctrl u_ctrl (.clk(clk), .rst(rst), .c(c_if));
  assign c_if.opcode = r_ir[31:26];
  assign c_if.funct = r_ir[5:0];
  assign w_imm = sext16(r_ir[15:0]);
  assign w_b = c_if.b_sel == B_REG ? r_b : c_if.b_sel == B_ZEXT ? {16'h0, r_ir[15:0]} : w_imm;
  assign w_sum = r_a + w_b;
  assign w_diff = r_a - w_b;
  assign w_sra = $signed(r_b) >>> r_ir[10:6];
  assign w_lt = $signed(r_a) < $signed(w_b);
  always_comb
    w_y = c_if.alu_op == ALU_SUB ? w_diff :
          c_if.alu_op == ALU_OR  ? (r_a | w_b) :
          c_if.alu_op == ALU_LUI ? {r_ir[15:0], 16'h0} :
          c_if.alu_op == ALU_SLT ? {31'h0, w_lt} :
          c_if.alu_op == ALU_SRA ? w_sra : w_sum;
  assign c_if.flags.zero = w_y == '0;
  assign c_if.flags.positive = !w_y[31] && (w_y != '0);
  assign c_if.flags.signed_less = w_lt;
  assign c_if.flags.overflow = c_if.alu_op == ALU_SUB ? (r_a[31] != w_b[31]) && (w_diff[31] != r_a[31])
                                                      : (r_a[31] == w_b[31]) && (w_sum[31] != r_a[31]);
  assign w_dst = c_if.reg_dst == DST_RD ? r_ir[15:11] : c_if.reg_dst == DST_RT ? r_ir[20:16] : 5'd31;
  assign w_wd = c_if.wb_src == WB_MEM ? r_mdr : c_if.wb_src == WB_PC ? r_pc : r_alu;
  // PC already holds PC+4 after fetch, so branch/jump targets build on r_pc directly
  assign w_npc = c_if.npc_sel == NPC_BR ? r_pc + {w_imm[29:0], 2'b00} :
                 c_if.npc_sel == NPC_J  ? {r_pc[31:28], r_ir[25:0], 2'b00} :
                 c_if.npc_sel == NPC_JR ? r_a : r_pc + 32'd4;
  assign w_im_idx = IW'((r_pc - PC_RESET) >> 2);
  assign w_dm_idx = r_alu[DW+1:2];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_RESET;
      r_ir <= '0;
      r_a <= '0;
      r_b <= '0;
      r_alu <= '0;
      r_mdr <= '0;
    end else begin
      if (c_if.pc_write) r_pc <= w_npc;
      if (c_if.ir_write) r_ir <= r_im[w_im_idx];
      if (c_if.ab_write) r_a <= r_gpr[r_ir[25:21]];
      if (c_if.ab_write) r_b <= r_gpr[r_ir[20:16]];
      if (c_if.alu_write) r_alu <= w_y;
      if (c_if.mdr_write) r_mdr <= r_dm[w_dm_idx];
    end
  end
  for (genvar i = 0; i < 32; i++) begin : g_gpr
    always_ff @(posedge clk)
      if (rst) r_gpr[i] <= '0;
      else if (i != 0 && c_if.reg_write && w_dst == 5'(i)) r_gpr[i] <= w_wd;
  end
  for (genvar i = 0; i < DM_WORDS; i++) begin : g_dm
    always_ff @(posedge clk)
      if (rst) r_dm[i] <= '0;
      else if (c_if.mem_write && w_dm_idx == DW'(i)) r_dm[i] <= r_b;
  end
endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// tb_mips_multicycle_cpu: directed program with cycle-exact architectural state checks,
// including a reset asserted mid-lw followed by an identical rerun.
module tb_mips_multicycle_cpu;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mips_multicycle_cpu dut (.clk(clk), .rst(rst));
  mips_ctrl_if mon_if ();
  assign mon_if.state = dut.c_if.state;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc"}, dut.r_pc, 32'h0000_3000);
    chk({tag, " state"}, 32'(mon_if.state), 32'd0);
    chk({tag, " r1"}, dut.r_gpr[1], 32'h0);
    chk({tag, " r31"}, dut.r_gpr[31], 32'h0);
    chk({tag, " dm2"}, dut.r_dm[2], 32'h0);
  endtask

  task automatic run_program();
    tick(4);  chk("ori r1", dut.r_gpr[1], 32'h0000_1234);
    tick(4);  chk("lui r2", dut.r_gpr[2], 32'h8000_0000);
              chk("pc after 2", dut.r_pc, 32'h0000_3008);
    tick(12); chk("addu r3", dut.r_gpr[3], 32'h0000_2468);
              chk("subu r4", dut.r_gpr[4], 32'hFFFF_EDCC);
              chk("slt r5", dut.r_gpr[5], 32'h1);
    tick(4);  chk("sra r6", dut.r_gpr[6], 32'hF800_0000);
    tick(4);  chk("sw dm2", dut.r_dm[2], 32'h0000_1234);
    tick(4);  chk("lw pending r7", dut.r_gpr[7], 32'h0);
              chk("lw state wb_mem", 32'(mon_if.state), 32'd6);
    tick(1);  chk("lw r7", dut.r_gpr[7], 32'h0000_1234);
    tick(8);  chk("lui/ori r8", dut.r_gpr[8], 32'h7FFF_FFFF);
    tick(4);  chk("addi ovf r9", dut.r_gpr[9], 32'h0);
    tick(4);  chk("addi r9", dut.r_gpr[9], 32'h7FFF_FFFE);
    tick(3);  chk("beq taken pc", dut.r_pc, 32'h0000_3038);
    tick(3);  chk("beq not taken pc", dut.r_pc, 32'h0000_303C);
    tick(4);  chk("ori r11", dut.r_gpr[11], 32'h0000_0011);
              chk("skipped r10", dut.r_gpr[10], 32'h0);
    tick(3);  chk("jal pc", dut.r_pc, 32'h0000_3100);
              chk("jal r31", dut.r_gpr[31], 32'h0000_3044);
    tick(4);  chk("sub ori r13", dut.r_gpr[13], 32'h0000_0033);
    tick(3);  chk("jr pc", dut.r_pc, 32'h0000_3044);
    tick(4);  chk("ret ori r12", dut.r_gpr[12], 32'h0000_0022);
    tick(3);  chk("j loop pc", dut.r_pc, 32'h0000_3048);
    tick(6);  chk("j loop hold pc", dut.r_pc, 32'h0000_3048);
              chk("r0 zero", dut.r_gpr[0], 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dut.r_im[i] = 32'h0;
    dut.r_im[0]  = 32'h3401_1234;  // ori  $1,$0,0x1234
    dut.r_im[1]  = 32'h3C02_8000;  // lui  $2,0x8000
    dut.r_im[2]  = 32'h0021_1821;  // addu $3,$1,$1
    dut.r_im[3]  = 32'h0001_2023;  // subu $4,$0,$1
    dut.r_im[4]  = 32'h0081_282A;  // slt  $5,$4,$1
    dut.r_im[5]  = 32'h0002_3103;  // sra  $6,$2,4
    dut.r_im[6]  = 32'hAC01_0008;  // sw   $1,8($0)
    dut.r_im[7]  = 32'h8C07_0008;  // lw   $7,8($0)
    dut.r_im[8]  = 32'h3C08_7FFF;  // lui  $8,0x7FFF
    dut.r_im[9]  = 32'h3508_FFFF;  // ori  $8,$8,0xFFFF
    dut.r_im[10] = 32'h2109_0001;  // addi $9,$8,1
    dut.r_im[11] = 32'h2109_FFFF;  // addi $9,$8,-1
    dut.r_im[12] = 32'h1021_0001;  // beq  $1,$1,+1
    dut.r_im[13] = 32'h340A_0BAD;  // ori  $10,$0,0xBAD
    dut.r_im[14] = 32'h1020_0001;  // beq  $1,$0,+1
    dut.r_im[15] = 32'h340B_0011;  // ori  $11,$0,0x11
    dut.r_im[16] = 32'h0C00_0C40;  // jal  0x3100
    dut.r_im[17] = 32'h340C_0022;  // ori  $12,$0,0x22
    dut.r_im[18] = 32'h0800_0C12;  // j    0x3048
    dut.r_im[64] = 32'h340D_0033;  // ori  $13,$0,0x33
    dut.r_im[65] = 32'h03E0_0008;  // jr   $31
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset("reset");
    run_program();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(31);
    chk("mid state mem_rd", 32'(mon_if.state), 32'd5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset("mid reset");
    run_program();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
